// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
// Holds bus widths, reset/enable levels and FSM state encodings.
package regfile_wr_arbiter_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic RstEnable    = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_STARVED = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arb2.sv
// Two-way round-robin picker for the low-priority writers.
// Ports: clk, rst (sync active-low), busy (port taken), req0/req1
// (valids), gnt0/gnt1 (one-hot combinational grants).
module regfile_wr_arbiter_rr_arb2
    import regfile_wr_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic busy,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // 0 prefers req0, 1 prefers req1
    logic rr_ptr;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst != RstEnable && !busy) begin
            if (req0 && (!req1 || !rr_ptr)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            rr_ptr <= 1'b0;
        end else if (gnt0) begin
            rr_ptr <= 1'b1;
        end else if (gnt1) begin
            rr_ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port among WB (strict priority), the
// divider and the debug port (round-robin valid/ready).
// Ports: clk, rst (sync active-low); wb_we/wb_waddr/wb_wdata;
// div_* and dbg_* handshakes; registered we/waddr/wdata to the
// regfile; registered stall_req to ctrl while a writer is starved.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DATA_W       = RegBus,
    parameter int ADDR_W       = RegAddrBus,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              div_valid,
    input  logic [ADDR_W-1:0] div_waddr,
    input  logic [DATA_W-1:0] div_wdata,
    output logic              div_ready,
    input  logic              dbg_valid,
    input  logic [ADDR_W-1:0] dbg_waddr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              stall_req
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             wb_occ;
    logic [CNT_W-1:0] div_cnt, div_cnt_n;
    logic [CNT_W-1:0] dbg_cnt, dbg_cnt_n;
    logic             hit;
    state_t           state, state_n;

    // A WB write to $0 is a no-op and leaves the port free
    assign wb_occ = wb_we && (wb_waddr != '0);

    regfile_wr_arbiter_rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .busy (wb_occ),
        .req0 (div_valid),
        .req1 (dbg_valid),
        .gnt0 (div_ready),
        .gnt1 (dbg_ready)
    );

    always_comb begin
        div_cnt_n = div_cnt;
        if (!div_valid || div_ready) begin
            div_cnt_n = '0;
        end else if (div_cnt != LIMIT) begin
            div_cnt_n = div_cnt + 1'b1;
        end
    end

    always_comb begin
        dbg_cnt_n = dbg_cnt;
        if (!dbg_valid || dbg_ready) begin
            dbg_cnt_n = '0;
        end else if (dbg_cnt != LIMIT) begin
            dbg_cnt_n = dbg_cnt + 1'b1;
        end
    end

    // Judged on next counts so stall_req rises the cycle after the
    // limit is reached and falls the cycle after the transfer
    assign hit = (div_cnt_n == LIMIT) || (dbg_cnt_n == LIMIT);

    always_comb begin
        state_n = state;
        unique case (state)
            ST_NORMAL:  if (hit)  state_n = ST_STARVED;
            ST_STARVED: if (!hit) state_n = ST_NORMAL;
            default:    state_n = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state   <= ST_NORMAL;
            div_cnt <= '0;
            dbg_cnt <= '0;
        end else begin
            state   <= state_n;
            div_cnt <= div_cnt_n;
            dbg_cnt <= dbg_cnt_n;
        end
    end

    assign stall_req = (state == ST_STARVED);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            we    <= WriteDisable;
            waddr <= '0;
            wdata <= '0;
        end else if (wb_occ) begin
            we    <= WriteEnable;
            waddr <= wb_waddr;
            wdata <= wb_wdata;
        end else if (div_ready) begin
            we    <= (div_waddr != '0);
            waddr <= div_waddr;
            wdata <= div_wdata;
        end else if (dbg_ready) begin
            we    <= (dbg_waddr != '0);
            waddr <= dbg_waddr;
            wdata <= dbg_wdata;
        end else begin
            we    <= WriteDisable;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a cycle model.
// Drives inputs just after posedge, checks on negedge.
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_we;
    logic [AW-1:0] wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          div_valid;
    logic [AW-1:0] div_waddr;
    logic [DW-1:0] div_wdata;
    logic          div_ready;
    logic          dbg_valid;
    logic [AW-1:0] dbg_waddr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          stall_req;

    int n_run = 0;
    int n_fail = 0;

    regfile_wr_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .div_valid(div_valid), .div_waddr(div_waddr),
        .div_wdata(div_wdata), .div_ready(div_ready),
        .dbg_valid(dbg_valid), .dbg_waddr(dbg_waddr),
        .dbg_wdata(dbg_wdata), .dbg_ready(dbg_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: who wins, what the regfile sees, how long each waits
    bit          m_ptr = 0;
    bit          m_we = 0;
    int          m_waddr = 0;
    logic [DW-1:0] m_wdata = '0;
    int          m_wdiv = 0;
    int          m_wdbg = 0;
    bit          m_on = 0;

    function automatic bit m_gdiv();
        bit occ = wb_we && wb_waddr != 0;
        return rst && !occ && div_valid && (!dbg_valid || !m_ptr);
    endfunction

    function automatic bit m_gdbg();
        bit occ = wb_we && wb_waddr != 0;
        return rst && !occ && dbg_valid && !m_gdiv();
    endfunction

    always @(posedge clk) begin
        bit gd, gg;
        gd = m_gdiv();
        gg = m_gdbg();
        if (!rst) begin
            m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = '0;
            m_wdiv = 0; m_wdbg = 0;
        end else begin
            if (wb_we && wb_waddr != 0) begin
                m_we = 1; m_waddr = int'(wb_waddr); m_wdata = wb_wdata;
            end else if (gd) begin
                m_we = div_waddr != 0;
                m_waddr = int'(div_waddr); m_wdata = div_wdata;
            end else if (gg) begin
                m_we = dbg_waddr != 0;
                m_waddr = int'(dbg_waddr); m_wdata = dbg_wdata;
            end else begin
                m_we = 0;
            end
            if (gd) m_ptr = 1;
            else if (gg) m_ptr = 0;
            m_wdiv = (!div_valid || gd) ? 0 : (m_wdiv < LIM ? m_wdiv + 1 : LIM);
            m_wdbg = (!dbg_valid || gg) ? 0 : (m_wdbg < LIM ? m_wdbg + 1 : LIM);
        end
        m_on = 1;
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("m_div_ready", 64'(div_ready), 64'(m_gdiv()));
            chk("m_dbg_ready", 64'(dbg_ready), 64'(m_gdbg()));
            chk("m_we", 64'(we), 64'(m_we));
            chk("m_waddr", 64'(waddr), 64'(m_waddr));
            chk("m_wdata", 64'(wdata), 64'(m_wdata));
            chk("m_stall", 64'(stall_req),
                64'(m_wdiv == LIM || m_wdbg == LIM));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit hit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0;
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        div_valid = 1; div_waddr = 7; div_wdata = 32'h0000_D1D1;
        dbg_valid = 1; dbg_waddr = 9; dbg_wdata = 32'h0000_DB6D;

        // reset with both valid
        tick(); tick(); tick();
        @(negedge clk);
        chk("rst_we", 64'(we), 0);
        chk("rst_stall", 64'(stall_req), 0);
        chk("rst_div_rdy", 64'(div_ready), 0);
        chk("rst_dbg_rdy", 64'(dbg_ready), 0);
        tick();
        rst = 1;
        @(negedge clk);
        chk("first_div", 64'(div_ready), 1);
        chk("first_not_dbg", 64'(dbg_ready), 0);

        // round robin div, dbg, div, dbg
        tick();
        @(negedge clk);
        chk("rr1_waddr", 64'(waddr), 7);
        chk("rr1_wdata", 64'(wdata), 64'h0000_D1D1);
        chk("rr2_dbg", 64'(dbg_ready), 1);
        tick();
        @(negedge clk);
        chk("rr2_waddr", 64'(waddr), 9);
        chk("rr3_div", 64'(div_ready), 1);
        tick();
        @(negedge clk);
        chk("rr3_waddr", 64'(waddr), 7);
        tick();
        @(negedge clk);
        chk("rr4_waddr", 64'(waddr), 9);
        chk("rr4_we", 64'(we), 1);
        div_valid = 0; dbg_valid = 0;

        // WB priority
        tick();
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEAD_BEEF;
        div_valid = 1; div_waddr = 12; div_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("wb_blocks_div", 64'(div_ready), 0);
        tick();
        wb_we = 0;
        @(negedge clk);
        chk("wb_we", 64'(we), 1);
        chk("wb_waddr", 64'(waddr), 5);
        chk("wb_wdata", 64'(wdata), 64'hDEAD_BEEF);
        chk("div_after_wb", 64'(div_ready), 1);
        tick();
        div_valid = 0;
        @(negedge clk);
        chk("div_waddr", 64'(waddr), 12);

        // WB to $0 frees the port; dbg write to $0 gives we=0
        tick();
        wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFF_FFFF;
        dbg_valid = 1; dbg_waddr = 0; dbg_wdata = 32'hAAAA_5555;
        @(negedge clk);
        chk("zero_dbg_rdy", 64'(dbg_ready), 1);
        tick();
        wb_we = 0; dbg_valid = 0;
        @(negedge clk);
        chk("zero_we", 64'(we), 0);
        tick();

        // starvation by continuous WB writes
        wb_we = 1; wb_waddr = 3; wb_wdata = 32'h0000_0333;
        div_valid = 1; div_waddr = 11; div_wdata = 32'hCAFE_F00D;
        tick(); tick(); tick();
        @(negedge clk);
        chk("stall_c4", 64'(stall_req), 0);
        tick();
        @(negedge clk);
        chk("stall_c5", 64'(stall_req), 1);
        tick(); tick();
        @(negedge clk);
        chk("stall_hold", 64'(stall_req), 1);
        wb_we = 0;
        #1;
        chk("starved_div_rdy", 64'(div_ready), 1);
        tick();
        div_valid = 0;
        @(negedge clk);
        chk("unstall", 64'(stall_req), 0);
        chk("starved_waddr", 64'(waddr), 11);
        chk("starved_wdata", 64'(wdata), 64'hCAFE_F00D);
        tick();

        // reset mid-wait clears counters
        wb_we = 1; div_valid = 1; div_waddr = 13;
        div_wdata = 32'h0BAD_0BAD;
        tick(); tick();
        rst = 0;
        tick();
        rst = 1;
        @(negedge clk);
        chk("midrst_we", 64'(we), 0);
        chk("midrst_stall", 64'(stall_req), 0);
        tick(); tick();
        @(negedge clk);
        chk("midrst_no_stall", 64'(stall_req), 0);
        tick();
        wb_we = 0;
        @(negedge clk);
        chk("midrst_div_rdy", 64'(div_ready), 1);
        tick();
        div_valid = 0;
        @(negedge clk);
        chk("midrst_waddr", 64'(waddr), 13);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single regfile write port (we/waddr/wdata) among three writers: the pipeline WB stage, the multi-cycle divider result path, and the debug write port. WB has strict priority. Divider and debug are served round-robin through valid/ready handshakes. A starvation monitor raises stall_req to ctrl so the pipeline inserts bubbles until a starved low-priority writer is served. Sits between WB/div/debug and regfile; all outputs to regfile are registered.

Parameters:
DATA_W, 32, write data width (RegBus)
ADDR_W, 5, register address width (RegAddrBus)
STARVE_LIMIT, 4, consecutive blocked cycles before stall_req is raised (min 1)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous reset, active-low (rst==0 at posedge resets)
wb_we  in  1  WB stage write request, no backpressure
wb_waddr  in  ADDR_W  WB destination
wb_wdata  in  DATA_W  WB data
div_valid  in  1  divider result pending
div_waddr  in  ADDR_W  divider destination
div_wdata  in  DATA_W  divider data
div_ready  out  1  divider grant (combinational)
dbg_valid  in  1  debug write pending
dbg_waddr  in  ADDR_W  debug destination
dbg_wdata  in  DATA_W  debug data
dbg_ready  out  1  debug grant (combinational)
we  out  1  to regfile write enable (registered)
waddr  out  ADDR_W  to regfile (registered)
wdata  out  DATA_W  to regfile (registered)
stall_req  out  1  to ctrl, request pipeline stall (registered)

Behaviour:
- Reset (rst==0 at posedge): we=0, waddr=0, wdata=0, stall_req=0, rr_ptr=0 (div preferred), wait counters=0, state NORMAL. div_ready/dbg_ready forced 0 while rst==0.
- WB "occupies" the port when wb_we==1 and wb_waddr!=0. A WB write to $0 is a no-op and frees the port.
- Grant, evaluated combinationally each cycle: if WB occupies, no low grant. Else if exactly one of div_valid/dbg_valid is high, that one is granted. If both are high, rr_ptr picks (0=div, 1=dbg).
- Handshake: a transfer occurs when valid&&ready. Data must stay stable while valid&&!ready. Valid may not drop before transfer.
- Output register: on the next posedge, we/waddr/wdata take the winner (WB or the granted requester). If none, we=0 and waddr/wdata hold. A granted write to $0 completes the handshake but drives we=0. Latency is one cycle from acceptance to we at regfile; regfile's read bypass covers same-cycle readers.
- rr_ptr: after a div grant it becomes 1; after a dbg grant it becomes 0; otherwise it holds.
- Wait counters (div, dbg): increment while valid&&!ready, saturating at STARVE_LIMIT. Clear on transfer or when valid==0.
- FSM NORMAL -> STARVED when either counter reaches STARVE_LIMIT. In STARVED, stall_req=1, registered, so it asserts the cycle after the limit is hit.
- FSM STARVED -> NORMAL on the cycle after the starved requester(s) transfer, with all counters below the limit. stall_req deasserts with the state.
- Pipeline contract: ctrl holds wb_we=0 while stall_req=1. If WB still writes, WB still wins (correctness first) and STARVED persists.
- Simultaneous events: a WB write plus both low requesters valid gives WB the port; both counters increment.
- Reset mid-handshake drops the pending grant. Requesters must hold valid, and are served after reset.

Decomposition:
- Shared package/defines: RegBus, RegAddrBus, RstEnable (=1'b0 for this block), WriteEnable, ZeroWord, and FSM state encodings ST_NORMAL/ST_STARVED.
- One natural sub-module: rr_arb2, a 2-way round-robin picker holding rr_ptr with valid inputs, a port-busy input, and one-hot grant outputs.

Test Plan:
- Reset: hold rst=0 for 3 cycles with all valids=1 -> we=0, stall_req=0, div_ready=dbg_ready=0. Release -> first grant goes to div (rr_ptr=0).
- WB priority: wb_we=1, wb_waddr=5, wb_wdata=0xDEADBEEF, div_valid=1 -> div_ready=0; next cycle we=1, waddr=5, wdata=0xDEADBEEF.
- Round-robin: div and dbg both valid every cycle, no WB -> grants alternate div, dbg, div, dbg; regfile sees matching waddr/wdata one cycle after each grant.
- $0 handling: wb_we=1, wb_waddr=0 with dbg_valid=1, dbg_waddr=0 -> dbg_ready=1 (WB frees the port), next cycle we=0.
- Starvation: wb_we=1 (waddr=3) every cycle, div_valid=1, STARVE_LIMIT=4 -> stall_req=1 on cycle 5. Drop wb_we -> div granted; stall_req returns to 0 one cycle after transfer.
- Reset mid-wait: div blocked 2 cycles, then rst=0 for one cycle -> counters clear and stall_req stays 0; div is served after release.
